spn_core_param: RTL and testbench

Parametrised, iterative substitution-permutation-network cipher core, one round per clock. Generalises the SPN unit in three ways: block width and round count are parameters, both directions have valid/ready handshakes, and the output is held under backpressure. It sits behind the `spn_if` bus: it accepts an opcode, a data block and a key, and returns the result plus a 2-bit status.

---
 rtl/spn_core_param_if.sv | 28 ++
 rtl/spn_core_param.sv | 190 +++++++++++++++++++
 tb/tb_spn_core_param.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/spn_core_param_if.sv
// Request/response bus for spn_core_param.
// Request side: in_valid/in_ready handshake carrying opcode, data_in and symmetric_secret_key.
// Response side: out_valid/out_ready handshake carrying data_out and the 2-bit status (valid).
// master: the requester/consumer; slave: the cipher core.
interface spn_core_param_if #(
   parameter int BLOCK_W = 16,
   parameter int KEY_W   = 2 * BLOCK_W
) ();
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         opcode;
   logic [BLOCK_W-1:0] data_in;
   logic [KEY_W-1:0]   symmetric_secret_key;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] data_out;
   logic [1:0]         valid;

   modport master (
      output in_valid, opcode, data_in, symmetric_secret_key, out_ready,
      input  in_ready, out_valid, data_out, valid
   );

   modport slave (
      input  in_valid, opcode, data_in, symmetric_secret_key, out_ready,
      output in_ready, out_valid, data_out, valid
   );
endinterface

// File: rtl/spn_core_param.sv
// Iterative substitution-permutation-network cipher core, one round per clock.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - spn_core_param_if.slave: request (in_valid/in_ready, opcode, data_in,
//          symmetric_secret_key) and held response (out_valid/out_ready, data_out, valid)
// Opcodes: 00 nop, 01 encrypt, 10 decrypt, 11 undefined (answered with status 11, data 0).
module spn_core_param #(
   parameter int BLOCK_W = 16,
   parameter int KEY_W   = 2 * BLOCK_W,
   parameter int ROUNDS  = 4
) (
   input logic               clk,
   input logic               rst,
   spn_core_param_if.slave   bus
);

   localparam int CNT_W = $clog2(ROUNDS + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ROUNDS - 1);

   if (KEY_W != 2 * BLOCK_W) begin : g_bad_key_w
      $error("spn_core_param: KEY_W must equal 2*BLOCK_W");
   end
   if ((BLOCK_W % 4 != 0) || (BLOCK_W < 8)) begin : g_bad_block_w
      $error("spn_core_param: BLOCK_W must be a multiple of 4 and at least 8");
   end
   if ((ROUNDS < 1) || (ROUNDS > 15)) begin : g_bad_rounds
      $error("spn_core_param: ROUNDS must be in 1..15");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [BLOCK_W-1:0] x_q, x_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic               dec_q, dec_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BLOCK_W-1:0] dout_q, dout_d;
   logic [1:0]         status_q, status_d;

   function automatic logic [3:0] sbox(input logic [3:0] n);
      logic [3:0] o;
      case (n)
         4'h0: o = 4'hC;  4'h1: o = 4'h5;  4'h2: o = 4'h6;  4'h3: o = 4'hB;
         4'h4: o = 4'h9;  4'h5: o = 4'h0;  4'h6: o = 4'hA;  4'h7: o = 4'hD;
         4'h8: o = 4'h3;  4'h9: o = 4'hE;  4'hA: o = 4'hF;  4'hB: o = 4'h8;
         4'hC: o = 4'h4;  4'hD: o = 4'h7;  4'hE: o = 4'h1;  default: o = 4'h2;
      endcase
      return o;
   endfunction

   function automatic logic [3:0] sbox_inv(input logic [3:0] n);
      logic [3:0] o;
      case (n)
         4'h0: o = 4'h5;  4'h1: o = 4'hE;  4'h2: o = 4'hF;  4'h3: o = 4'h8;
         4'h4: o = 4'hC;  4'h5: o = 4'h1;  4'h6: o = 4'h2;  4'h7: o = 4'hD;
         4'h8: o = 4'hB;  4'h9: o = 4'h4;  4'hA: o = 4'h6;  4'hB: o = 4'h3;
         4'hC: o = 4'h0;  4'hD: o = 4'h7;  4'hE: o = 4'h9;  default: o = 4'hA;
      endcase
      return o;
   endfunction

   function automatic logic [BLOCK_W-1:0] sub_layer(input logic [BLOCK_W-1:0] v,
                                                    input logic inv);
      logic [BLOCK_W-1:0] o;
      o = '0;
      for (int n = 0; n < BLOCK_W / 4; n++) begin
         o[4*n +: 4] = inv ? sbox_inv(v[4*n +: 4]) : sbox(v[4*n +: 4]);
      end
      return o;
   endfunction

   // Bit i goes to i*(BLOCK_W/4) mod (BLOCK_W-1); the top bit is a fixed point.
   // BLOCK_W/4 and BLOCK_W-1 are coprime, so this is always a bijection.
   function automatic logic [BLOCK_W-1:0] perm(input logic [BLOCK_W-1:0] v, input logic inv);
      logic [BLOCK_W-1:0] o;
      int                 d;
      o = '0;
      for (int i = 0; i < BLOCK_W - 1; i++) begin
         d = (i * (BLOCK_W / 4)) % (BLOCK_W - 1);
         if (inv) o[i] = v[d];
         else     o[d] = v[i];
      end
      o[BLOCK_W-1] = v[BLOCK_W-1];
      return o;
   endfunction

   // Low half of the key rotated left by 4*r; built as a chain of nibble rotations so
   // no variable-width shifter or modulo is needed.
   function automatic logic [BLOCK_W-1:0] round_key(input logic [KEY_W-1:0] k, input int r);
      logic [KEY_W-1:0] t;
      t = k;
      for (int s = 0; s < ROUNDS; s++) begin
         if (s < r) t = {t[KEY_W-5:0], t[KEY_W-1 -: 4]};
      end
      return t[BLOCK_W-1:0];
   endfunction

   // One cipher step on the working block.
   logic [BLOCK_W-1:0] k_cur, k_last, t_mid, x_step;
   always_comb begin
      k_last = round_key(key_q, ROUNDS);
      if (!dec_q) begin
         k_cur  = round_key(key_q, int'(cnt_q));
         t_mid  = sub_layer(x_q ^ k_cur, 1'b0);
         x_step = (cnt_q == LAST_STEP) ? (t_mid ^ k_last) : perm(t_mid, 1'b0);
      end else begin
         // Decryption walks the round keys downwards: step j uses K_(ROUNDS-1-j).
         k_cur  = round_key(key_q, ROUNDS - 1 - int'(cnt_q));
         t_mid  = (cnt_q == '0) ? (x_q ^ k_last) : perm(x_q, 1'b1);
         x_step = sub_layer(t_mid, 1'b1) ^ k_cur;
      end
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      key_d    = key_q;
      dec_d    = dec_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      status_d = status_q;
      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               case (bus.opcode)
                  2'b01, 2'b10: begin
                     x_d     = bus.data_in;
                     key_d   = bus.symmetric_secret_key;
                     dec_d   = bus.opcode[1];
                     cnt_d   = '0;
                     state_d = StRun;
                  end
                  2'b11: begin
                     dout_d   = '0;
                     status_d = 2'b11;
                     state_d  = StDone;
                  end
                  default: ;  // nop is consumed without a response
               endcase
            end
         end
         StRun: begin
            x_d = x_step;
            if (cnt_q == LAST_STEP) begin
               dout_d   = x_step;
               status_d = dec_q ? 2'b10 : 2'b01;
               state_d  = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               dout_d   = '0;
               status_d = 2'b00;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         x_q      <= '0;
         key_q    <= '0;
         dec_q    <= 1'b0;
         cnt_q    <= '0;
         dout_q   <= '0;
         status_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         key_q    <= key_d;
         dec_q    <= dec_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         status_q <= status_d;
      end
   end

   // Not ready while reset is asserted, even though the state register already reads idle.
   assign bus.in_ready  = (state_q == StIdle) && !rst;
   assign bus.out_valid = (state_q == StDone);
   assign bus.data_out  = dout_q;
   assign bus.valid     = status_q;

endmodule

// File: tb/tb_spn_core_param.sv
// Directed bench for spn_core_param: one instance with ROUNDS=1 and one with the
// default ROUNDS=4, both BLOCK_W=16. Inputs are shared; in_valid is steered to one DUT.
module tb_spn_core_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel4;
   logic        req;
   logic [1:0]  op;
   logic [15:0] din;
   logic [31:0] key;
   logic        oready;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spn_core_param_if #(.BLOCK_W(16), .KEY_W(32)) b1 ();
   spn_core_param_if #(.BLOCK_W(16), .KEY_W(32)) b4 ();

   spn_core_param #(.BLOCK_W(16), .KEY_W(32), .ROUNDS(1)) u_r1 (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

   spn_core_param #(.BLOCK_W(16), .KEY_W(32), .ROUNDS(4)) u_r4 (
      .clk (clk),
      .rst (rst),
      .bus (b4.slave)
   );

   assign b1.in_valid             = req & ~sel4;
   assign b4.in_valid             = req & sel4;
   assign b1.opcode               = op;
   assign b4.opcode               = op;
   assign b1.data_in              = din;
   assign b4.data_in              = din;
   assign b1.symmetric_secret_key = key;
   assign b4.symmetric_secret_key = key;
   assign b1.out_ready            = oready;
   assign b4.out_ready            = oready;

   logic        irdy, ovld;
   logic [15:0] dout;
   logic [1:0]  st;
   assign irdy = sel4 ? b4.in_ready  : b1.in_ready;
   assign ovld = sel4 ? b4.out_valid : b1.out_valid;
   assign dout = sel4 ? b4.data_out  : b1.data_out;
   assign st   = sel4 ? b4.valid     : b1.valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge with the selected DUT idle. Returns the response and the
   // number of rising edges after the acceptance edge until out_valid was seen.
   task automatic do_op(input logic use4, input logic [1:0] o, input logic [15:0] d,
                        input logic [31:0] k, output logic [15:0] r, output logic [1:0] s,
                        output int lat);
      sel4 = use4; op = o; din = d; key = k; req = 1'b1;
      @(posedge clk); #1;
      // Scramble request fields: the core must have registered them.
      req = 1'b0; op = 2'b00; din = 16'($urandom); key = $urandom;
      lat = 0;
      @(negedge clk);
      while (!ovld && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      r = dout;
      s = st;
      @(negedge clk);
   endtask

   logic [15:0] r, c, p, xx;
   logic [1:0]  s;
   logic [31:0] kk;
   int          lat;
   int          seen;

   initial begin
      rst = 1'b1; sel4 = 1'b0; req = 1'b0; op = 2'b00; din = '0; key = '0; oready = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_irdy_r1", 32'(b1.in_ready), 32'd0);
      chk("rst_irdy_r4", 32'(b4.in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_irdy_after", 32'(b1.in_ready), 32'd1);
      chk("rst_ovld", 32'(b4.out_valid), 32'd0);
      chk("rst_dout", 32'(b4.data_out), 32'h0);
      chk("rst_st", 32'(b4.valid), 32'd0);
      @(negedge clk);

      // ROUNDS=1 directed vectors
      do_op(1'b0, 2'b01, 16'h0123, 32'h0, r, s, lat);
      chk("r1_enc0123", 32'(r), 32'hC56B);
      chk("r1_enc0123_st", 32'(s), 32'd1);
      chk("r1_enc0123_lat", 32'(lat), 32'd1);
      chk("r1_xfer_ovld", 32'(ovld), 32'd0);
      chk("r1_xfer_irdy", 32'(irdy), 32'd1);
      chk("r1_xfer_dout", 32'(dout), 32'h0);
      chk("r1_xfer_st", 32'(st), 32'd0);
      do_op(1'b0, 2'b01, 16'h0000, 32'h0, r, s, lat);
      chk("r1_enc0000", 32'(r), 32'hCCCC);
      do_op(1'b0, 2'b01, 16'h0000, 32'h0000_000F, r, s, lat);
      chk("r1_enc_kf", 32'(r), 32'hCC32);
      chk("r1_enc_kf_st", 32'(s), 32'd1);
      do_op(1'b0, 2'b10, 16'hCC32, 32'h0000_000F, r, s, lat);
      chk("r1_dec_kf", 32'(r), 32'h0000);
      chk("r1_dec_kf_st", 32'(s), 32'd2);

      // Undefined opcode
      do_op(1'b0, 2'b11, 16'h1234, 32'hDEAD_BEEF, r, s, lat);
      chk("op11_dout", 32'(r), 32'h0);
      chk("op11_st", 32'(s), 32'd3);
      chk("op11_lat", 32'(lat), 32'd0);

      // Nop is consumed silently
      sel4 = 1'b0; op = 2'b00; din = 16'h5555; req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("nop_irdy", 32'(irdy), 32'd1);
         chk("nop_ovld", 32'(ovld), 32'd0);
      end
      req = 1'b0;

      // ROUNDS=4 hand-computed vector and its inverse
      do_op(1'b1, 2'b01, 16'h0000, 32'h0, r, s, lat);
      chk("r4_enc0", 32'(r), 32'h7B44);
      chk("r4_enc0_lat", 32'(lat), 32'd4);
      do_op(1'b1, 2'b10, 16'h7B44, 32'h0, r, s, lat);
      chk("r4_dec", 32'(r), 32'h0000);
      chk("r4_dec_st", 32'(s), 32'd2);
      chk("r4_dec_lat", 32'(lat), 32'd4);

      // Round trip with assorted keys/blocks
      for (int i = 0; i < 3; i++) begin
         kk = $urandom;
         xx = 16'($urandom);
         do_op(1'b1, 2'b01, xx, kk, c, s, lat);
         chk("rt_enc_lat", 32'(lat), 32'd4);
         chk("rt_enc_st", 32'(s), 32'd1);
         do_op(1'b1, 2'b10, c, kk, p, s, lat);
         chk("rt_dec", 32'(p), 32'(xx));
      end

      // Backpressure: DONE held, new requests ignored, no accept on the transfer edge
      oready = 1'b0;
      do_op(1'b1, 2'b01, 16'h0000, 32'h0, r, s, lat);
      chk("bp_lat", 32'(lat), 32'd4);
      sel4 = 1'b1; op = 2'b01; din = 16'hFFFF; key = 32'h1234_5678; req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_ovld", 32'(ovld), 32'd1);
         chk("bp_dout", 32'(dout), 32'h7B44);
         chk("bp_st", 32'(st), 32'd1);
         chk("bp_irdy", 32'(irdy), 32'd0);
         @(negedge clk);
      end
      oready = 1'b1;
      @(negedge clk);
      chk("bp_rel_ovld", 32'(ovld), 32'd0);
      chk("bp_rel_irdy", 32'(irdy), 32'd1);
      chk("bp_rel_dout", 32'(dout), 32'h0);
      chk("bp_rel_st", 32'(st), 32'd0);
      req = 1'b0;
      @(negedge clk);

      // Reset in the middle of RUN
      sel4 = 1'b1; op = 2'b01; din = 16'h0000; key = 32'h0; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_ovld", 32'(ovld), 32'd0);
      chk("mid_rst_st", 32'(st), 32'd0);
      chk("mid_rst_irdy", 32'(irdy), 32'd1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ovld) seen++;
      end
      chk("mid_rst_no_result", 32'(seen), 32'd0);
      do_op(1'b1, 2'b01, 16'h0000, 32'h0, r, s, lat);
      chk("post_rst_enc", 32'(r), 32'h7B44);
      chk("post_rst_st", 32'(s), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
